// File: rtl/bus_dma_pkg.sv
// bus_dma_pkg: shared types and constants for the bus_dma copy/fill engine.
//   state_t     - transfer FSM states
//   WSTRB_*     - write-strobe encodings for read and full-word write
//   MODE_*      - transfer mode encodings on the mode input
//   word_align  - clears the byte-offset bits of a bus address
package bus_dma_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_RD_GAP,
      ST_WR,
      ST_WR_GAP,
      ST_FIN
   } state_t;

   localparam logic [3:0] WSTRB_READ = 4'h0;
   localparam logic [3:0] WSTRB_WORD = 4'hF;

   localparam logic MODE_COPY = 1'b0;
   localparam logic MODE_FILL = 1'b1;

   function automatic logic [31:0] word_align(input logic [31:0] a);
      return a & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/bus_dma_if.sv
// bus_dma_if: PicoRV32-style native memory bus between one initiator and
// one responder.
//   valid - request from initiator
//   ready - acknowledge from responder
//   addr  - word-aligned byte address
//   wdata - write data
//   wstrb - 4'h0 read, 4'hF word write
//   rdata - read data, meaningful while ready=1
// Modports: master (initiator side), slave (responder side).
interface bus_dma_if;

   logic        valid;
   logic        ready;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic [31:0] rdata;

   modport master (
      output valid, addr, wdata, wstrb,
      input  ready, rdata
   );

   modport slave (
      input  valid, addr, wdata, wstrb,
      output ready, rdata
   );

endinterface

// File: rtl/bus_watchdog.sv
// bus_watchdog: counts cycles a bus request waits for acknowledge.
//   clk, rst - clock and synchronous active-high reset
//   clear    - zero the counter (held while no request is outstanding)
//   waiting  - request outstanding and not acknowledged this cycle
//   expired  - this is the TIMEOUT_CYCLES-th unacknowledged cycle
module bus_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic waiting,
   output logic expired
);

   localparam int unsigned W = $clog2(TIMEOUT_CYCLES + 1);

   logic [W-1:0] count;

   // Flagged during the last waiting cycle so the initiator can drop its
   // request on the very edge at which the count would reach the limit.
   assign expired = waiting && (count == W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else if (waiting && !expired) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/bus_dma.sv
// bus_dma: word-granular copy/fill initiator on the native memory bus.
//   clk, rst    - clock and synchronous active-high reset
//   start       - begin a transfer (ignored while busy)
//   mode        - MODE_COPY reads src then writes dst, MODE_FILL writes fill_value
//   src_addr    - source byte address (low two bits ignored)
//   dst_addr    - destination byte address (low two bits ignored)
//   len         - transfer length in 32-bit words
//   fill_value  - data written in fill mode
//   busy        - transfer in progress
//   done        - one-cycle pulse ending every accepted start
//   error       - bus timeout occurred, held until the next accepted start
//   words_done  - completed destination writes
//   mem         - bus initiator port
module bus_dma
   import bus_dma_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned LEN_BITS       = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                mode,
   input  logic [31:0]         src_addr,
   input  logic [31:0]         dst_addr,
   input  logic [LEN_BITS-1:0] len,
   input  logic [31:0]         fill_value,
   output logic                busy,
   output logic                done,
   output logic                error,
   output logic [LEN_BITS-1:0] words_done,
   bus_dma_if.master           mem
);

   state_t state_q, state_d;

   logic [31:0]         src_ptr;
   logic [31:0]         dst_ptr;
   logic [31:0]         data_q;
   logic [31:0]         fill_q;
   logic [31:0]         addr_q;
   logic [31:0]         wdata_q;
   logic [3:0]          wstrb_q;
   logic [LEN_BITS-1:0] remaining;
   logic [LEN_BITS-1:0] words_q;
   logic                mode_q;
   logic                error_q;

   logic bus_active;
   logic wd_clear;
   logic wd_waiting;
   logic expired;
   logic accept;
   logic enter_rd;
   logic enter_wr;

   assign accept   = (state_q == ST_IDLE) && start;
   assign enter_rd = (state_d == ST_RD) && (state_q != ST_RD);
   assign enter_wr = (state_d == ST_WR) && (state_q != ST_WR);

   bus_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .clear   (wd_clear),
      .waiting (wd_waiting),
      .expired (expired)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (len == '0) begin
                  state_d = ST_FIN;
               end else if (mode == MODE_FILL) begin
                  state_d = ST_WR;
               end else begin
                  state_d = ST_RD;
               end
            end
         end
         ST_RD: begin
            if (mem.ready) begin
               state_d = ST_RD_GAP;
            end else if (expired) begin
               state_d = ST_FIN;
            end
         end
         ST_RD_GAP: state_d = ST_WR;
         ST_WR: begin
            if (mem.ready) begin
               state_d = (remaining == LEN_BITS'(1)) ? ST_FIN : ST_WR_GAP;
            end else if (expired) begin
               state_d = ST_FIN;
            end
         end
         ST_WR_GAP: state_d = (mode_q == MODE_FILL) ? ST_WR : ST_RD;
         ST_FIN:    state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Output decode
   always_comb begin
      bus_active = (state_q == ST_RD) || (state_q == ST_WR);
      busy       = (state_q != ST_IDLE);
      done       = (state_q == ST_FIN);
      error      = error_q;
      words_done = words_q;
      mem.valid  = bus_active;
      mem.addr   = addr_q;
      mem.wdata  = wdata_q;
      mem.wstrb  = wstrb_q;
      wd_clear   = !bus_active;
      wd_waiting = bus_active && !mem.ready;
   end

   // Datapath: pointers, counters and the registered bus request fields.
   // Bus fields load only on entry to RD/WR so they stay frozen while valid.
   // On the IDLE exit the pointers are not yet loaded, so the aligned inputs
   // are used directly.
   always_ff @(posedge clk) begin
      if (rst) begin
         src_ptr   <= '0;
         dst_ptr   <= '0;
         data_q    <= '0;
         fill_q    <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         remaining <= '0;
         words_q   <= '0;
         mode_q    <= MODE_COPY;
         error_q   <= 1'b0;
      end else begin
         if (accept) begin
            error_q   <= 1'b0;
            words_q   <= '0;
            src_ptr   <= word_align(src_addr);
            dst_ptr   <= word_align(dst_addr);
            remaining <= len;
            mode_q    <= mode;
            fill_q    <= fill_value;
         end

         case (state_q)
            ST_RD: begin
               if (mem.ready) begin
                  data_q  <= mem.rdata;
                  src_ptr <= src_ptr + 32'd4;
               end else if (expired) begin
                  error_q <= 1'b1;
               end
            end
            ST_WR: begin
               if (mem.ready) begin
                  dst_ptr   <= dst_ptr + 32'd4;
                  words_q   <= words_q + LEN_BITS'(1);
                  remaining <= remaining - LEN_BITS'(1);
               end else if (expired) begin
                  error_q <= 1'b1;
               end
            end
            default: ;
         endcase

         if (enter_rd) begin
            addr_q  <= accept ? word_align(src_addr) : src_ptr;
            wstrb_q <= WSTRB_READ;
         end

         if (enter_wr) begin
            addr_q  <= accept ? word_align(dst_addr) : dst_ptr;
            wdata_q <= accept ? fill_value
                              : ((mode_q == MODE_FILL) ? fill_q : data_q);
            wstrb_q <= WSTRB_WORD;
         end
      end
   end

endmodule

// File: tb/tb_bus_dma.sv
// tb_bus_dma: scoreboard bench for bus_dma. Expected bus transactions and
// done pulses are queued as each transfer is issued; a negedge monitor pops
// and compares them whenever the DUT completes a handshake or pulses done.
module tb_bus_dma;
   import bus_dma_pkg::*;

   localparam int unsigned LB = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          mode = 1'b0;
   logic [31:0]   src_addr = '0;
   logic [31:0]   dst_addr = '0;
   logic [LB-1:0] len = '0;
   logic [31:0]   fill_value = '0;
   logic          busy;
   logic          done;
   logic          error;
   logic [LB-1:0] words_done;

   bus_dma_if bus ();

   bus_dma #(
      .TIMEOUT_CYCLES(8),
      .LEN_BITS(LB)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .mode       (mode),
      .src_addr   (src_addr),
      .dst_addr   (dst_addr),
      .len        (len),
      .fill_value (fill_value),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .words_done (words_done),
      .mem        (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        chk;
   } txn_t;

   typedef struct {
      logic          err;
      logic [LB-1:0] words;
      int            delta;
   } done_t;

   txn_t  exp_q[$];
   done_t done_q[$];
   txn_t  mon_t;
   done_t mon_d;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int start_cyc = 0;
   int valid_cnt = 0;
   int busy_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- responder model ----------------
   logic [31:0] ram [16];
   int lat_mode = 1;   // 0 = never ready, <0 = random 1..5, else fixed
   int cur_lat = 1;
   int wcnt = 0;

   function automatic int slot(input logic [31:0] a);
      case (a)
         32'h0010_0000: return 0;
         32'h0010_0004: return 1;
         32'h0010_0008: return 2;
         32'h0010_000C: return 3;
         32'h0020_0000: return 4;
         32'h0020_0004: return 5;
         32'h0020_0008: return 6;
         32'h0020_000C: return 7;
         32'h0000_0100: return 8;
         32'h0000_0104: return 9;
         32'h0000_0108: return 10;
         32'hFFFF_FFF8: return 11;
         32'hFFFF_FFFC: return 12;
         32'h0000_0000: return 13;
         default:       return 15;
      endcase
   endfunction

   initial begin
      for (int i = 0; i < 16; i++) ram[i] = 32'hBADB_AD00 + i;
      ram[0]  = 32'h11;
      ram[1]  = 32'h22;
      ram[2]  = 32'h33;
      ram[3]  = 32'h44;
      ram[11] = 32'hA1;
      ram[12] = 32'hA2;
      ram[13] = 32'hA3;
   end

   always @(posedge clk) begin
      if (rst) begin
         bus.ready <= 1'b0;
         bus.rdata <= '0;
         wcnt      <= 0;
         cur_lat   <= 1;
      end else if (bus.valid && !bus.ready) begin
         if (cur_lat != 0 && wcnt + 1 >= cur_lat) begin
            bus.ready <= 1'b1;
            wcnt      <= 0;
            if (bus.wstrb == WSTRB_WORD) ram[slot(bus.addr)] <= bus.wdata;
            else bus.rdata <= ram[slot(bus.addr)];
         end else begin
            wcnt <= wcnt + 1;
         end
      end else begin
         bus.ready <= 1'b0;
         wcnt      <= 0;
         cur_lat   <= (lat_mode < 0) ? int'($urandom_range(5, 1)) : lat_mode;
      end
   end

   // ---------------- monitor / scoreboard ----------------
   logic        prev_valid = 1'b0;
   logic        prev_hs = 1'b0;
   logic        prev_done = 1'b0;
   logic        unstable = 1'b0;
   logic [31:0] prev_addr = '0;
   logic [31:0] prev_wdata = '0;
   logic [3:0]  prev_wstrb = '0;
   logic        chg;

   assign chg = prev_valid && !prev_hs && bus.valid &&
                ({bus.addr, bus.wdata, bus.wstrb} != {prev_addr, prev_wdata, prev_wstrb});

   always @(negedge clk) begin
      if (rst) begin
         prev_valid <= 1'b0;
         prev_hs    <= 1'b0;
         prev_done  <= 1'b0;
         unstable   <= 1'b0;
      end else begin
         if (bus.valid) valid_cnt <= valid_cnt + 1;
         if (busy) busy_cnt <= busy_cnt + 1;

         if (prev_hs) begin
            tests++;
            if (bus.valid) begin
               fails++;
               $display("FAIL bus_gap: got valid=1 right after handshake, required 0 (addr 0x%08h)", bus.addr);
            end
         end

         if (bus.valid && bus.ready) begin
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL bus_unexpected: got addr 0x%08h wstrb %h, required no transaction", bus.addr, bus.wstrb);
            end else begin
               mon_t = exp_q.pop_front();
               if (bus.addr !== mon_t.addr || bus.wstrb !== mon_t.wstrb ||
                   (mon_t.chk && bus.wdata !== mon_t.wdata) || unstable || chg) begin
                  fails++;
                  $display("FAIL bus_txn: got addr 0x%08h wdata 0x%08h wstrb %h stable=%0b, required addr 0x%08h wdata 0x%08h wstrb %h stable=1",
                           bus.addr, bus.wdata, bus.wstrb, !(unstable || chg), mon_t.addr, mon_t.wdata, mon_t.wstrb);
               end
            end
         end

         if (done) begin
            tests++;
            if (done_q.size() == 0) begin
               fails++;
               $display("FAIL done_unexpected: got done=1 words=%0d err=%0b, required no done", words_done, error);
            end else begin
               mon_d = done_q.pop_front();
               if (prev_done || !busy || error !== mon_d.err || words_done !== mon_d.words ||
                   (mon_d.delta >= 0 && (cyc - start_cyc) != mon_d.delta)) begin
                  fails++;
                  $display("FAIL done_pulse: got err=%0b words=%0d cycles=%0d prev_done=%0b busy=%0b, required err=%0b words=%0d cycles=%0d prev_done=0 busy=1",
                           error, words_done, cyc - start_cyc, prev_done, busy, mon_d.err, mon_d.words, mon_d.delta);
               end
            end
         end

         if (bus.valid && bus.ready) unstable <= 1'b0;
         else if (chg) unstable <= 1'b1;
         prev_valid <= bus.valid;
         prev_hs    <= bus.valid && bus.ready;
         prev_done  <= done;
         prev_addr  <= bus.addr;
         prev_wdata <= bus.wdata;
         prev_wstrb <= bus.wstrb;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   task automatic exp_rd(input logic [31:0] a);
      exp_q.push_back('{addr: a, wdata: 32'h0, wstrb: WSTRB_READ, chk: 1'b0});
   endtask

   task automatic exp_wr(input logic [31:0] a, input logic [31:0] d);
      exp_q.push_back('{addr: a, wdata: d, wstrb: WSTRB_WORD, chk: 1'b1});
   endtask

   task automatic exp_done(input logic e, input logic [LB-1:0] w, input int delta);
      done_q.push_back('{err: e, words: w, delta: delta});
   endtask

   task automatic issue(input logic m, input logic [31:0] s, input logic [31:0] d,
                        input logic [LB-1:0] n, input logic [31:0] f);
      @(negedge clk);
      start      = 1'b1;
      mode       = m;
      src_addr   = s;
      dst_addr   = d;
      len        = n;
      fill_value = f;
      start_cyc  = cyc;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy && n < 300);
      check("idle_reached", {63'd0, busy}, 64'd0);
   endtask

   task automatic drained(input string name);
      check(name, 64'(exp_q.size() + done_q.size()), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL sim_timeout: got no finish, required finish");
      $fatal(1, "simulation time limit");
   end

   // ---------------- directed tests ----------------
   initial begin
      int b0, v0;
      logic found;

      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset_ctrl", {40'd0, busy, done, error, bus.valid, bus.wstrb, words_done}, 64'd0);
      check("reset_bus", {bus.addr, bus.wdata}, 64'd0);

      // Copy 4 words, 1-cycle responder, with an ignored start mid-transfer
      lat_mode = 1;
      for (int i = 0; i < 4; i++) begin
         exp_rd(32'h0010_0000 + 32'(4 * i));
         exp_wr(32'h0020_0000 + 32'(4 * i), 32'h11 * 32'(i + 1));
      end
      exp_done(1'b0, 16'd4, 24);
      b0 = busy_cnt; v0 = valid_cnt;
      issue(MODE_COPY, 32'h0010_0000, 32'h0020_0000, 16'd4, 32'h0);
      repeat (5) @(negedge clk);
      start = 1'b1; mode = MODE_FILL; len = 16'd5; dst_addr = 32'h0000_0100; fill_value = 32'hFFFF_0000;
      @(negedge clk);
      start = 1'b0;
      wait_idle();
      check("copy_busy_cycles", 64'(busy_cnt - b0), 64'd24);
      check("copy_valid_cycles", 64'(valid_cnt - v0), 64'd16);
      for (int i = 0; i < 4; i++) check("copy_dst_word", 64'(ram[4 + i]), 64'(32'h11 * (i + 1)));
      check("copy_error", {63'd0, error}, 64'd0);
      drained("copy_drained");

      // Fill 3 words
      for (int i = 0; i < 3; i++) exp_wr(32'h0000_0100 + 32'(4 * i), 32'hDEAD_BEEF);
      exp_done(1'b0, 16'd3, 9);
      b0 = busy_cnt; v0 = valid_cnt;
      issue(MODE_FILL, 32'h1234_5678, 32'h0000_0100, 16'd3, 32'hDEAD_BEEF);
      wait_idle();
      check("fill_busy_cycles", 64'(busy_cnt - b0), 64'd9);
      check("fill_valid_cycles", 64'(valid_cnt - v0), 64'd6);
      for (int i = 0; i < 3; i++) check("fill_mem_word", 64'(ram[8 + i]), 64'hDEAD_BEEF);
      drained("fill_drained");

      // Timeout: responder never acknowledges
      lat_mode = 0;
      exp_done(1'b1, 16'd0, 9);
      b0 = busy_cnt; v0 = valid_cnt;
      issue(MODE_COPY, 32'h0010_0000, 32'h0060_0000, 16'd2, 32'h0);
      wait_idle();
      check("timeout_valid_cycles", 64'(valid_cnt - v0), 64'd8);
      check("timeout_busy_cycles", 64'(busy_cnt - b0), 64'd9);
      check("timeout_error_held", {47'd0, error, words_done}, {47'd0, 1'b1, 16'd0});
      drained("timeout_drained");

      // len = 0: done after one busy cycle, no bus activity, error cleared
      lat_mode = 1;
      exp_done(1'b0, 16'd0, 1);
      b0 = busy_cnt; v0 = valid_cnt;
      issue(MODE_COPY, 32'h0010_0000, 32'h0020_0000, 16'd0, 32'h0);
      wait_idle();
      check("len0_busy_cycles", 64'(busy_cnt - b0), 64'd1);
      check("len0_valid_cycles", 64'(valid_cnt - v0), 64'd0);
      check("len0_error_cleared", {63'd0, error}, 64'd0);
      drained("len0_drained");

      // Unaligned addresses are forced to word alignment
      exp_rd(32'h0010_0000);
      exp_wr(32'h0040_0000, 32'h11);
      exp_done(1'b0, 16'd1, 6);
      issue(MODE_COPY, 32'h0010_0003, 32'h0040_0001, 16'd1, 32'h0);
      wait_idle();
      drained("unaligned_drained");

      // Address wrap with random responder latency
      lat_mode = -1;
      exp_rd(32'hFFFF_FFF8); exp_wr(32'h0003_0000, 32'hA1);
      exp_rd(32'hFFFF_FFFC); exp_wr(32'h0003_0004, 32'hA2);
      exp_rd(32'h0000_0000); exp_wr(32'h0003_0008, 32'hA3);
      exp_done(1'b0, 16'd3, -1);
      issue(MODE_COPY, 32'hFFFF_FFF8, 32'h0003_0000, 16'd3, 32'h0);
      wait_idle();
      drained("wrap_copy_drained");

      exp_wr(32'hFFFF_FFFC, 32'h5A5A_5A5A);
      exp_wr(32'h0000_0000, 32'h5A5A_5A5A);
      exp_done(1'b0, 16'd2, -1);
      issue(MODE_FILL, 32'h0, 32'hFFFF_FFFC, 16'd2, 32'h5A5A_5A5A);
      wait_idle();
      check("wrap_fill_word0", 64'(ram[13]), 64'h5A5A_5A5A);
      drained("wrap_fill_drained");

      // Reset during the second write
      lat_mode = 3;
      exp_rd(32'h0010_0000);
      exp_wr(32'h0050_0000, 32'h11);
      exp_rd(32'h0010_0004);
      issue(MODE_COPY, 32'h0010_0000, 32'h0050_0000, 16'd3, 32'h0);
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         if (bus.valid && bus.wstrb == WSTRB_WORD && bus.addr == 32'h0050_0004) found = 1'b1;
         else @(negedge clk);
      end
      check("rst_reached_second_wr", {63'd0, found}, 64'd1);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_ctrl", {40'd0, bus.valid, busy, done, error, bus.wstrb, words_done}, 64'd0);
      check("rst_mid_bus", {bus.addr, bus.wdata}, 64'd0);
      rst = 1'b0;
      drained("rst_mid_drained");

      lat_mode = 1;
      exp_rd(32'h0010_0008);
      exp_wr(32'h0050_0008, 32'h33);
      exp_done(1'b0, 16'd1, 6);
      issue(MODE_COPY, 32'h0010_0008, 32'h0050_0008, 16'd1, 32'h0);
      wait_idle();
      drained("after_rst_drained");

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
